// File: rtl/ibex_pkg.sv
// Shared types for the register-file write-side path.
package ibex_pkg;

    // Widest register the write path carries; narrower DataWidth uses the low bits.
    localparam int unsigned RfDataWidthMax = 32;

    // One pending register-file write.
    typedef struct packed {
        logic [4:0]                waddr;
        logic [RfDataWidthMax-1:0] wdata;
        logic                      dummy;
    } rf_wr_req_t;

    // True when the target lies outside x0..x15 on an RV32E core.
    function automatic logic rf_addr_illegal(input logic rv32e, input logic [4:0] waddr);
        return rv32e & waddr[4];
    endfunction

endpackage

// File: rtl/ibex_rf_wr_fifo.sv
// Shift-style FIFO for buffered execute writes; head is always entry 0 and
// every entry is exposed so the top can build the pending-write mask.
module ibex_rf_wr_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  rf_wr_req_t             wdata,
    output rf_wr_req_t             head,
    output logic                   full,
    output logic                   empty,
    output rf_wr_req_t [Depth-1:0] entries,
    output logic       [Depth-1:0] entry_valid
);
    localparam int unsigned CW = $clog2(Depth + 1);

    logic [CW-1:0]          count;
    logic [CW-1:0]          count_d;
    logic [CW-1:0]          wr_idx;
    rf_wr_req_t [Depth-1:0] mem;
    rf_wr_req_t [Depth-1:0] mem_d;
    logic                   push_eff;
    logic                   pop_eff;

    assign full     = (count == CW'(Depth));
    assign empty    = (count == '0);
    assign push_eff = push & ~full;
    assign pop_eff  = pop & ~empty;
    assign head     = mem[0];
    assign entries  = mem;

    for (genvar g = 0; g < Depth; g++) begin : g_vld
        assign entry_valid[g] = (count > CW'(g));
    end

    // Next storage: shift toward the head on pop, then drop the new entry
    // into the first free slot after the shift.
    always_comb begin
        mem_d   = mem;
        count_d = count;
        wr_idx  = pop_eff ? count - 1'b1 : count;
        if (pop_eff) begin
            for (int i = 0; i < Depth - 1; i++) mem_d[i] = mem[i + 1];
        end
        if (push_eff) begin
            for (int i = 0; i < Depth; i++) begin
                if (CW'(i) == wr_idx) mem_d[i] = wdata;
            end
        end
        if (push_eff && !pop_eff) count_d = count + 1'b1;
        else if (!push_eff && pop_eff) count_d = count - 1'b1;
    end

    // Occupancy is reset; payload needs no reset since entry_valid gates it.
    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else     count <= count_d;
        mem <= mem_d;
    end

endmodule

// File: rtl/ibex_rf_write_arbiter.sv
// Merges execute results and load responses onto the register file's single
// write port. LSU always wins the port; execute writes queue behind it in
// order, and bypass straight to the port only when nothing is queued.
module ibex_rf_write_arbiter
    import ibex_pkg::*;
#(
    parameter int unsigned DataWidth = 32,  // must not exceed RfDataWidthMax
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned FifoDepth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    input  logic                 ex_dummy_i,
    input  logic                 lsu_valid_i,
    input  logic [4:0]           lsu_waddr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 rf_dummy_wb_o,
    output logic [31:0]          pending_o,
    output logic                 err_o
);
    rf_wr_req_t                 ex_req, lsu_req, out_q, out_d, fifo_head;
    rf_wr_req_t [FifoDepth-1:0] fifo_entries;
    logic       [FifoDepth-1:0] fifo_vld;
    logic fifo_full, fifo_empty, push, pop;
    logic out_vld_q, out_vld_d, err_q;
    logic ex_acc, ex_bad, lsu_bad, ex_wr, lsu_wr;

    // Ready looks only at the current occupancy, never at a same-cycle pop.
    assign ex_ready_o = ~fifo_full;
    assign ex_acc     = ex_valid_i & ex_ready_o;
    assign ex_bad     = rf_addr_illegal(RV32E, ex_waddr_i);
    assign lsu_bad    = rf_addr_illegal(RV32E, lsu_waddr_i);
    // Writes that must reach the port: illegal targets are dropped, and x0 is
    // only written for dummy instructions (LSU never carries the dummy flag).
    assign ex_wr      = ex_acc & ~ex_bad & ((ex_waddr_i != 5'd0) | ex_dummy_i);
    assign lsu_wr     = lsu_valid_i & ~lsu_bad & (lsu_waddr_i != 5'd0);

    // Pack both sources into the common request format.
    always_comb begin
        ex_req                       = '0;
        ex_req.waddr                 = ex_waddr_i;
        ex_req.wdata[DataWidth-1:0]  = ex_wdata_i;
        ex_req.dummy                 = ex_dummy_i;
        lsu_req                      = '0;
        lsu_req.waddr                = lsu_waddr_i;
        lsu_req.wdata[DataWidth-1:0] = lsu_wdata_i;
    end

    // Port selection: LSU > queued EX > EX bypass; an EX write that loses
    // the port is queued so it stays younger than the LSU write.
    always_comb begin
        out_d     = out_q;
        out_vld_d = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        if (lsu_wr) begin
            out_vld_d = 1'b1;
            out_d     = lsu_req;
            push      = ex_wr;
        end else if (!fifo_empty) begin
            out_vld_d = 1'b1;
            out_d     = fifo_head;
            pop       = 1'b1;
            push      = ex_wr;
        end else if (ex_wr) begin
            out_vld_d = 1'b1;
            out_d     = ex_req;
        end
    end

    ibex_rf_wr_fifo #(
        .Depth(FifoDepth)
    ) u_fifo (
        .clk        (clk_i),
        .rst        (rst_i),
        .push       (push),
        .pop        (pop),
        .wdata      (ex_req),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .entries    (fifo_entries),
        .entry_valid(fifo_vld)
    );

    // Output stage register and the one-cycle illegal-address pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_vld_q <= 1'b0;
            out_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
            err_q     <= (lsu_valid_i & lsu_bad) | (ex_acc & ex_bad);
        end
    end

    // Hazard mask: every register with a write queued or on the port.
    always_comb begin
        pending_o = '0;
        for (int i = 0; i < FifoDepth; i++) begin
            if (fifo_vld[i]) pending_o[fifo_entries[i].waddr] = 1'b1;
        end
        if (out_vld_q) pending_o[out_q.waddr] = 1'b1;
        pending_o[0] = 1'b0;
    end

    assign rf_we_o       = out_vld_q;
    assign rf_waddr_o    = out_q.waddr;
    assign rf_wdata_o    = out_q.wdata[DataWidth-1:0];
    assign rf_dummy_wb_o = out_vld_q & out_q.dummy;
    assign err_o         = err_q;

endmodule

// File: tb/tb_ibex_rf_write_arbiter.sv
// Directed plus random bench for ibex_rf_write_arbiter (RV32E=1, depth 2),
// checked against a queue-based model of the arbitration rules.
module tb_ibex_rf_write_arbiter;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_valid, ex_ready, ex_dummy;
    logic [4:0]    ex_waddr;
    logic [DW-1:0] ex_wdata;
    logic          lsu_valid;
    logic [4:0]    lsu_waddr;
    logic [DW-1:0] lsu_wdata;
    logic          rf_we, rf_dummy_wb, err;
    logic [4:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [31:0]   pending;

    ibex_rf_write_arbiter #(.DataWidth(DW), .RV32E(1'b1), .FifoDepth(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_waddr_i(ex_waddr),
        .ex_wdata_i(ex_wdata), .ex_dummy_i(ex_dummy),
        .lsu_valid_i(lsu_valid), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .rf_dummy_wb_o(rf_dummy_wb), .pending_o(pending), .err_o(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of younger EX writes waiting for the port and
    // the write currently expected on the port.
    typedef struct {
        logic [4:0]    a;
        logic [DW-1:0] d;
        logic          dm;
    } wr_t;
    wr_t  mq[$];
    wr_t  m_out;
    logic m_vld, m_err, m_rst;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic lv, input logic [4:0] la, input logic [DW-1:0] ld,
                         input logic ev, input logic [4:0] ea, input logic [DW-1:0] ed,
                         input logic edm);
        lsu_valid = lv; lsu_waddr = la; lsu_wdata = ld;
        ex_valid  = ev; ex_waddr  = ea; ex_wdata  = ed; ex_dummy = edm;
    endtask

    // Advance the model using the inputs presented this cycle.
    task automatic m_step();
        bit acc, lw, ew;
        m_rst = rst;
        if (rst) begin
            mq.delete();
            m_vld = 1'b0;
            m_out = '{5'd0, '0, 1'b0};
            m_err = 1'b0;
        end else begin
            acc   = ex_valid && (mq.size() < DEPTH);
            m_err = (lsu_valid && lsu_waddr >= 16) || (acc && ex_waddr >= 16);
            lw    = lsu_valid && lsu_waddr < 16 && lsu_waddr != 0;
            ew    = acc && ex_waddr < 16 && (ex_waddr != 0 || ex_dummy);
            // EX is younger than everything, so it joins the back of the line.
            if (ew) mq.push_back('{ex_waddr, ex_wdata, ex_dummy});
            if (lw) begin
                m_vld = 1'b1;
                m_out = '{lsu_waddr, lsu_wdata, 1'b0};
            end else if (mq.size() > 0) begin
                m_vld = 1'b1;
                m_out = mq.pop_front();
            end else begin
                m_vld = 1'b0;
            end
        end
    endtask

    function automatic logic [31:0] m_pending();
        logic [31:0] p = '0;
        foreach (mq[i]) p[mq[i].a] = 1'b1;
        if (m_vld) p[m_out.a] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic compare();
        chk("we", rf_we, m_vld);
        if (m_vld || m_rst) begin
            chk("waddr", rf_waddr, m_out.a);
            chk("wdata", rf_wdata, m_out.d);
        end
        chk("dummy", rf_dummy_wb, m_vld & m_out.dm);
        chk("pending", pending, m_pending());
        chk("err", err, m_err);
        chk("ready", ex_ready, mq.size() < DEPTH);
    endtask

    task automatic step();
        m_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        // Reset held two cycles with both sources requesting.
        drive(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0);
        step(); step();
        chk("rst_we", rf_we, 1'b0);
        chk("rst_pending", pending, 32'h0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("post_rst_ready", ex_ready, 1'b1);
        chk("post_rst_we", rf_we, 1'b0);

        // Single EX write goes straight to the port.
        drive(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0);
        step();
        chk("ex5_we", rf_we, 1'b1);
        chk("ex5_data", rf_wdata, 32'hDEADBEEF);
        chk("ex5_pend", pending, 32'h20);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("ex5_pend_clr", pending, 32'h0);

        // Same-address conflict: LSU first, EX second.
        drive(1, 5'd7, 32'h1, 1, 5'd7, 32'h2, 0);
        step();
        chk("conf_first", rf_wdata, 32'h1);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("conf_second", rf_wdata, 32'h2);
        chk("conf_pend", pending[7], 1'b1);
        step();

        // LSU holds the port four cycles while EX streams x1, x2, x3.
        n = 1;
        for (int c = 0; c < 10; c++) begin
            if (n <= 3 && ex_ready) begin
                drive(c < 4, 5'(10 + c), 32'(c), 1, 5'(n), 32'(100 + n), 0);
                n++;
            end else begin
                drive(c < 4, 5'(10 + c), 32'(c), n <= 3, 5'(n), 32'(100 + n), 0);
            end
            step();
            if (c == 2 || c == 3) chk("bp_ready_low", ex_ready, 1'b0);
        end

        // x0: non-dummy is swallowed, dummy is written.
        drive(0, 0, 0, 1, 5'd0, 32'h77, 0);
        step();
        chk("x0_nodummy_we", rf_we, 1'b0);
        drive(0, 0, 0, 1, 5'd0, 32'h55, 1);
        step();
        chk("x0_dummy_we", rf_we, 1'b1);
        chk("x0_dummy_flag", rf_dummy_wb, 1'b1);
        chk("x0_dummy_addr", rf_waddr, 5'd0);

        // Illegal RV32E target.
        drive(0, 0, 0, 1, 5'd16, 32'h9, 0);
        step();
        chk("x16_err", err, 1'b1);
        chk("x16_we", rf_we, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("x16_err_clr", err, 1'b0);

        // Fill the FIFO, then reset while full.
        for (int c = 0; c < 3; c++) begin
            drive(1, 5'd9, 32'(c), 1, 5'(c + 1), 32'(200 + c), 0);
            step();
        end
        chk("full_ready", ex_ready, 1'b0);
        rst = 1'b1;
        step();
        chk("rst_full_pend", pending, 32'h0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("rst_full_we", rf_we, 1'b0);
        step();

        // Random traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 9) < 4, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 9) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
